// File: rtl/util_pkg.sv
// util_pkg: shared IS/ROB/EX/ARF interface types and reorder-buffer sizing.
package util_pkg;
   localparam int ROB_INDEX_BITS = 3;
   localparam int ROB_ENTRIES = 2**ROB_INDEX_BITS;

   typedef logic [ROB_INDEX_BITS-1:0] ticket_t;

   typedef struct packed {
      logic        valid_request;
      logic        valid_dest;
      logic [4:0]  lreg;
      logic [5:0]  preg;
      logic [5:0]  ppreg;
      logic [5:0]  microoperation;
      logic [31:0] pc;
   } request_t;

   typedef struct packed {
      request_t request_2;
      request_t request_1;
   } new_entries_t;

   typedef struct packed {
      logic    is_full;
      logic    two_empty;
      ticket_t ticket;
   } to_issue_t;

   typedef struct packed {
      logic        valid;
      ticket_t     ticket;
      logic [31:0] data;
      logic        valid_exception;
      logic [3:0]  cause;
      logic [5:0]  preg;
   } ex_update_t;

   typedef struct packed {
      logic        valid_commit;
      logic        valid_write;
      logic        flushed;
      logic        valid_dest;
      logic [4:0]  ldst;
      logic [5:0]  pdst;
      logic [5:0]  ppdst;
      logic [31:0] data;
      logic [31:0] pc;
      ticket_t     ticket;
   } writeback_t;

   typedef struct packed {
      logic        valid;
      logic        pending;
      logic        flushed;
      logic        valid_exception;
      logic        valid_dest;
      logic [4:0]  lreg;
      logic [5:0]  preg;
      logic [5:0]  ppreg;
      logic [5:0]  microoperation;
      logic [31:0] pc;
      logic [3:0]  cause;
   } rob_entry_t;

   function automatic rob_entry_t alloc_entry(request_t r);
      rob_entry_t e;
      e = '0;
      e.valid = 1'b1;
      e.pending = 1'b1;
      e.valid_dest = r.valid_dest;
      e.lreg = r.lreg;
      e.preg = r.preg;
      e.ppreg = r.ppreg;
      e.microoperation = r.microoperation;
      e.pc = r.pc;
      return e;
   endfunction
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order ROB, dual allocation from issue, out-of-order completion,
// single in-order retirement; an exception at the head flushes everything.
module reorder_buffer
   import util_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  new_entries_t new_entries_i,
   output to_issue_t    to_issue_o,
   input  ex_update_t   ex_update_i,
   output writeback_t   writeback_o
);
   localparam int CW = ROB_INDEX_BITS + 1;

   rob_entry_t  rob_q [ROB_ENTRIES];
   logic [31:0] data_q [ROB_ENTRIES];
   ticket_t     head_q, head_d, tail_q, tail_d, tail_p1;
   logic [CW-1:0] count_q, count_d;
   rob_entry_t  head_e;
   logic        is_full, two_empty, acc_1, acc_2, commit, flush, unused_bits;

   assign head_e    = rob_q[head_q];
   assign tail_p1   = tail_q + 1'b1;
   assign is_full   = count_q == CW'(ROB_ENTRIES);
   assign two_empty = count_q <= CW'(ROB_ENTRIES - 2);
   assign acc_1     = new_entries_i.request_1.valid_request && !is_full;
   assign acc_2     = new_entries_i.request_1.valid_request && new_entries_i.request_2.valid_request && two_empty;
   assign commit    = head_e.valid && !head_e.pending;
   assign flush     = commit && head_e.valid_exception;
   assign to_issue_o = '{is_full: is_full, two_empty: two_empty, ticket: tail_q};
   assign unused_bits = ^{head_e.microoperation, head_e.cause, head_e.flushed, ex_update_i.preg};

   always_comb begin
      head_d  = flush ? '0 : head_q + ROB_INDEX_BITS'(commit);
      tail_d  = flush ? '0 : tail_q + ROB_INDEX_BITS'(acc_1) + ROB_INDEX_BITS'(acc_2);
      count_d = flush ? '0 : count_q + CW'(acc_1) + CW'(acc_2) - CW'(commit);
   end

   always_comb begin
      writeback_o = '0;
      if (commit) begin
         writeback_o.valid_commit = 1'b1;
         writeback_o.valid_write  = head_e.valid_dest && !head_e.valid_exception;
         writeback_o.flushed      = head_e.valid_exception;
         writeback_o.valid_dest   = head_e.valid_dest;
         writeback_o.ldst         = head_e.lreg;
         writeback_o.pdst         = head_e.preg;
         writeback_o.ppdst        = head_e.ppreg;
         writeback_o.data         = data_q[head_q];
         writeback_o.pc           = head_e.pc;
         writeback_o.ticket       = head_q;
      end
   end

   // Later assignments win: a flush overrides same-cycle allocation and completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < ROB_ENTRIES; i++) begin
            rob_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (ex_update_i.valid && rob_q[ex_update_i.ticket].valid) begin
            rob_q[ex_update_i.ticket].pending         <= 1'b0;
            rob_q[ex_update_i.ticket].valid_exception <= ex_update_i.valid_exception;
            rob_q[ex_update_i.ticket].cause           <= ex_update_i.cause;
            data_q[ex_update_i.ticket]                <= ex_update_i.data;
         end
         if (commit) rob_q[head_q].valid <= 1'b0;
         if (acc_1) rob_q[tail_q] <= alloc_entry(new_entries_i.request_1);
         if (acc_2) rob_q[tail_p1] <= alloc_entry(new_entries_i.request_2);
         if (flush)
            for (int i = 0; i < ROB_ENTRIES; i++) rob_q[i].valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench; allocations push expected retirements,
// a negedge monitor pops and compares every commit.
module tb_reorder_buffer;
   import util_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   new_entries_t new_entries_i;
   to_issue_t    to_issue_o;
   ex_update_t   ex_update_i;
   writeback_t   writeback_o;

   reorder_buffer dut (
      .clk(clk), .rst_n(rst_n), .new_entries_i(new_entries_i), .to_issue_o(to_issue_o),
      .ex_update_i(ex_update_i), .writeback_o(writeback_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [2:0] ticket; logic [31:0] pc; logic dest; } exp_t;
   exp_t        sb[$];
   logic [2:0]  pend[$];
   logic [31:0] exp_data [8];
   logic        exp_exc [8];
   int          mcount = 0;
   logic [2:0]  mtail = '0;
   int          checks = 0;
   int          fails = 0;

   function automatic request_t mk_req(input logic v, input logic [31:0] pc);
      request_t r;
      r.valid_request = v;
      r.valid_dest = pc[2] ^ pc[4];
      r.lreg = pc[6:2];
      r.preg = pc[7:2];
      r.ppreg = ~pc[7:2];
      r.microoperation = pc[5:0];
      r.pc = pc;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      new_entries_i = '0;
      ex_update_i = '0;
   endtask

   // n: 0 none, 1 slot 1 only, 2 both slots, 3 slot 2 only (must be ignored)
   task automatic drive_alloc(input int n, input logic [31:0] pc1, input logic [31:0] pc2, output int acc);
      to_issue_t w;
      logic a1, a2;
      w.is_full = (mcount == 8);
      w.two_empty = (mcount <= 6);
      w.ticket = mtail;
      checks++;
      if (to_issue_o !== w) begin
         fails++;
         $display("FAIL to_issue: got %b want %b (model count %0d)", to_issue_o, w, mcount);
      end
      new_entries_i.request_1 = mk_req(n == 1 || n == 2, pc1);
      new_entries_i.request_2 = mk_req(n >= 2, pc2);
      a1 = (n == 1 || n == 2) && mcount < 8;
      a2 = (n == 2) && mcount <= 6;
      acc = 0;
      if (a1) begin
         sb.push_back('{mtail, pc1, pc1[2] ^ pc1[4]});
         exp_exc[mtail] = 1'b0;
         pend.push_back(mtail);
         mtail++;
         mcount++;
         acc++;
      end
      if (a2) begin
         sb.push_back('{mtail, pc2, pc2[2] ^ pc2[4]});
         exp_exc[mtail] = 1'b0;
         pend.push_back(mtail);
         mtail++;
         mcount++;
         acc++;
      end
   endtask

   task automatic drive_cmp(input logic [2:0] t, input logic [31:0] d, input logic exc);
      ex_update_i.valid = 1'b1;
      ex_update_i.ticket = t;
      ex_update_i.data = d;
      ex_update_i.valid_exception = exc;
      ex_update_i.cause = exc ? 4'h2 : 4'h0;
      ex_update_i.preg = '0;
      exp_data[t] = d;
      exp_exc[t] = exc;
   endtask

   task automatic wait_drain(input int left, input string tag);
      int cyc = 0;
      while (sb.size() > left && cyc < 100) begin
         tick();
         cyc++;
      end
      checks++;
      if (sb.size() != left) begin
         fails++;
         $display("FAIL %s_drain: got %0d outstanding want %0d", tag, sb.size(), left);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [85:0] got, want;
      if (rst_n && writeback_o.valid_commit) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL commit_unexpected: got ticket %0d want no commit", writeback_o.ticket);
         end else begin
            e = sb.pop_front();
            got = {writeback_o.ticket, writeback_o.pc, writeback_o.data, writeback_o.valid_write,
                   writeback_o.flushed, writeback_o.ldst, writeback_o.pdst, writeback_o.ppdst};
            want = {e.ticket, e.pc, exp_data[e.ticket], e.dest && !exp_exc[e.ticket],
                    exp_exc[e.ticket], e.pc[6:2], e.pc[7:2], ~e.pc[7:2]};
            if (got !== want) begin
               fails++;
               $display("FAIL commit: got %h want %h", got, want);
            end
            mcount--;
            if (exp_exc[e.ticket]) begin
               sb.delete();
               mcount = 0;
               mtail = '0;
            end
         end
      end
   end

   task automatic test_reset();
      new_entries_i = '0;
      ex_update_i = '0;
      rst_n = 1'b0;
      #12;
      checks += 2;
      if (to_issue_o !== 5'b01000) begin fails++; $display("FAIL reset_to_issue: got %b want 01000", to_issue_o); end
      if (writeback_o !== '0) begin fails++; $display("FAIL reset_writeback: got %h want 0", writeback_o); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      checks += 2;
      if (to_issue_o !== 5'b01000) begin fails++; $display("FAIL idle_to_issue: got %b want 01000", to_issue_o); end
      if (writeback_o !== '0) begin fails++; $display("FAIL idle_writeback: got %h want 0", writeback_o); end
   endtask

   task automatic test_dual_alloc();
      int acc;
      drive_alloc(3, 32'h0F0, 32'h0F4, acc);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive_alloc(2, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), acc);
         tick();
      end
      drive_alloc(1, 32'h200, 32'h0, acc);
      tick();
      checks++;
      if (to_issue_o !== 5'b10000) begin fails++; $display("FAIL full_ignore: got %b want 10000", to_issue_o); end
   endtask

   task automatic test_ooo_complete();
      drive_cmp(3'd3, 32'hA3, 1'b0); tick();
      drive_cmp(3'd1, 32'hA1, 1'b0); tick();
      drive_cmp(3'd0, 32'hA0, 1'b0); tick();
      drive_cmp(3'd2, 32'hA2, 1'b0); tick();
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (!(writeback_o.valid_commit === 1'b1 && writeback_o.ticket === 3'(k))) begin
            fails++;
            $display("FAIL in_order_commit: got vc=%b ticket=%0d want vc=1 ticket=%0d", writeback_o.valid_commit, writeback_o.ticket, k);
         end
         tick();
      end
      checks++;
      if (writeback_o.valid_commit !== 1'b0) begin fails++; $display("FAIL head_pending: got vc=%b want 0", writeback_o.valid_commit); end
   endtask

   task automatic test_head_complete();
      drive_cmp(3'd4, 32'hB4, 1'b0);
      #1;
      checks++;
      if (writeback_o.valid_commit !== 1'b0) begin fails++; $display("FAIL head_bypass: got vc=%b want 0", writeback_o.valid_commit); end
      tick();
      checks++;
      if (!(writeback_o.valid_commit === 1'b1 && writeback_o.ticket === 3'd4)) begin
         fails++;
         $display("FAIL head_next_cycle: got vc=%b ticket=%0d want vc=1 ticket=4", writeback_o.valid_commit, writeback_o.ticket);
      end
      drive_cmp(3'd5, 32'hB5, 1'b0); tick();
      drive_cmp(3'd6, 32'hB6, 1'b0); tick();
      drive_cmp(3'd7, 32'hB7, 1'b0); tick();
      wait_drain(0, "head");
   endtask

   task automatic test_wrap();
      int allocated = 0;
      int cyc = 0;
      int acc, n;
      pend.delete();
      while (allocated < 20 && cyc < 200) begin
         if (cyc % 2 == 0 && pend.size() > 0) drive_cmp(pend.pop_front(), $urandom, 1'b0);
         n = (20 - allocated >= 2 && mcount < 6) ? 2 : 1;
         drive_alloc(n, 32'h400 + 32'(4 * allocated), 32'h404 + 32'(4 * allocated), acc);
         allocated += acc;
         tick();
         cyc++;
      end
      while (pend.size() > 0) begin
         drive_cmp(pend.pop_front(), $urandom, 1'b0);
         tick();
      end
      wait_drain(0, "wrap");
   endtask

   task automatic test_exception();
      logic [2:0] h;
      int acc;
      h = mtail;
      drive_alloc(2, 32'h600, 32'h604, acc); tick();
      drive_alloc(2, 32'h608, 32'h60C, acc); tick();
      drive_cmp(h, 32'hEE, 1'b1);
      tick();
      checks++;
      if (!(writeback_o.flushed === 1'b1 && writeback_o.valid_write === 1'b0 && writeback_o.ticket === h)) begin
         fails++;
         $display("FAIL flush_commit: got fl=%b vw=%b ticket=%0d want fl=1 vw=0 ticket=%0d", writeback_o.flushed, writeback_o.valid_write, writeback_o.ticket, h);
      end
      drive_alloc(2, 32'h700, 32'h704, acc);
      tick();
      checks += 2;
      if (to_issue_o !== 5'b01000) begin fails++; $display("FAIL flush_to_issue: got %b want 01000", to_issue_o); end
      if (writeback_o.valid_commit !== 1'b0) begin fails++; $display("FAIL flush_empty: got vc=%b want 0", writeback_o.valid_commit); end
      drive_cmp(3'(h + 3'd1), 32'h55, 1'b0);
      tick();
      checks += 2;
      if (writeback_o.valid_commit !== 1'b0) begin fails++; $display("FAIL stale_complete: got vc=%b want 0", writeback_o.valid_commit); end
      if (to_issue_o !== 5'b01000) begin fails++; $display("FAIL stale_to_issue: got %b want 01000", to_issue_o); end
   endtask

   task automatic test_async_reset();
      int acc;
      drive_alloc(2, 32'h800, 32'h804, acc);
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks += 2;
      if (to_issue_o !== 5'b01000) begin fails++; $display("FAIL async_reset_to_issue: got %b want 01000", to_issue_o); end
      if (writeback_o !== '0) begin fails++; $display("FAIL async_reset_writeback: got %h want 0", writeback_o); end
      sb.delete();
      pend.delete();
      mcount = 0;
      mtail = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      drive_alloc(0, 32'h0, 32'h0, acc);
      tick();
   endtask

   initial begin
      test_reset();
      test_dual_alloc();
      test_ooo_complete();
      test_head_complete();
      test_wrap();
      test_exception();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
